carregador_de_programa: RTL and testbench
=========================================

// Module: carregador_de_programa
// PURPOSE
//  Upstream loader for memoria_de_instrucoes. Takes a byte stream from a host link (UART RX or
//  debug port) over a valid/ready handshake and packs bytes big-endian into 32-bit words.
//  Drives the memory write port (we/addr/datain) at incrementing word addresses.
//  Holds the CPU (cpu_hold) while a program is being loaded.
// PARAMETERS
//  RAM_SIZE  1024  instruction memory depth in words; header counts above this are rejected
// PORTS
//  clk          in   1   clock; all state changes on the rising edge
//  reset        in   1   asynchronous, active-high reset
//  start        in   1   1-cycle pulse that begins a load (IDLE/DONE/ERR only)
//  byte_in      in   8   stream byte
//  byte_valid   in   1   byte_in is valid this cycle
//  byte_ready   out  1   loader accepts a byte this cycle (handshake = valid & ready)
//  we           out  1   instruction memory write enable
//  addr         out  32  instruction memory word address
//  datain       out  32  word written to instruction memory
//  cpu_hold     out  1   1 = CPU must not fetch or advance its PC
//  done         out  1   load completed successfully (level)
//  error        out  1   load rejected (level)
// BEHAVIOUR
//  Reset (async): state=IDLE; we, addr, datain, byte_ready, cpu_hold, done, error and the
//   byte/word counters all go to 0. Memory contents are not cleared.
//  States: IDLE, HDR, DATA, CSUM (CHECKSUM_EN only), DONE, ERR.
//  byte_ready=1 only in HDR, DATA and CSUM. cpu_hold=1 in HDR, DATA, CSUM and ERR.
//  Packing: 1st byte of each word -> [31:24], 4th byte -> [7:0]. A byte with valid=0 is ignored.
//   Gaps between bytes of any length are allowed.
//  IDLE/DONE/ERR + start: go to HDR, clear done, error, byte counter and word index.
//   start in any other state is ignored.
//  HDR: 4 bytes form N (word count). After the 4th byte:
//   N==0 -> DONE; N>RAM_SIZE -> ERR; otherwise -> DATA.
//  DATA, write timing: on the cycle after the 4th byte of word k is accepted,
//   we=1 for exactly one cycle with addr=k and datain=word.
//   byte_ready stays 1 during that cycle, so the stream never stalls.
//  DATA, completion: after word N-1 is written, go to DONE (or to CSUM if enabled).
//   addr holds its last value; we=0.
//  DONE: done=1 and cpu_hold=0 until the next start. ERR: error=1, cpu_hold=1, no writes.
//  Word index is 32 bits and never wraps, because N<=RAM_SIZE is enforced.
//  start and reset in the same cycle: reset wins.
// CONFIGURATION
//  CARREGADOR_CHECKSUM_EN defined:
//   - A running 32-bit sum (mod 2^32) is kept over all data words.
//   - After the last data word, 4 more bytes form the expected checksum.
//   - Match -> DONE; mismatch -> ERR. Data words are already written either way.
//   - For N==0 the checksum word is still received and is compared against 0.
//  Not defined: CSUM state and the adder are absent; DATA goes straight to DONE.
// TESTING
//  1 reset, start, bytes 00 00 00 02 11 22 33 44 AA BB CC DD
//    -> we pulse addr=0 data=0x11223344, then addr=1 data=0xAABBCCDD; done=1, cpu_hold=0.
//  2 start, header 00 00 00 00 -> DONE the cycle after the 4th byte; we never asserted.
//  3 header 0x00000401 (RAM_SIZE=1024) -> error=1, byte_ready=0, cpu_hold=1, no we; start clears error.
//  4 case 1 with byte_valid low on alternate cycles and byte_in=0xFF while invalid
//    -> identical writes; 0xFF never captured.
//  5 reset asserted after 2 data bytes -> all outputs 0 at once; next start writes from addr=0.
//  6 CARREGADOR_CHECKSUM_EN, case 1 plus BB DE 00 21 -> done=1; plus BB DE 00 22
//    -> error=1 (both words still written).

Source files
------------

// File: rtl/carregador_de_programa.sv
// carregador_de_programa: program loader for memoria_de_instrucoes.
//
// This module takes a byte stream over a valid/ready handshake. The first 4 bytes
// form a big-endian header N, which is the number of words to load. Each following
// group of 4 bytes is packed big-endian into one 32-bit word. Word k is written to
// the instruction memory at word address k. The CPU is held while the load runs
// and while the loader is in the error state.
//
// Optional feature: define CARREGADOR_CHECKSUM_EN to enable a trailing checksum.
// The checksum is 4 bytes, big-endian, and must equal the mod-2^32 sum of all data
// words. When the macro is not defined, the CSUM state and the adder are not built.
//
// Parameters
//   RAM_SIZE    instruction memory depth in words; a header N > RAM_SIZE is rejected
// Ports
//   clk         clock, rising edge
//   reset       asynchronous, active-high reset
//   start       1-cycle pulse; begins a load from IDLE, DONE or ERR
//   byte_in     stream byte
//   byte_valid  byte_in is valid this cycle
//   byte_ready  loader accepts a byte this cycle (HDR, DATA, CSUM)
//   we          memory write enable, 1-cycle pulse per word
//   addr        memory word address
//   datain      word written to memory
//   cpu_hold    CPU must not fetch (HDR, DATA, CSUM, ERR)
//   done        load completed successfully (level)
//   error       load rejected (level)
module carregador_de_programa #(
  parameter int unsigned RAM_SIZE = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        byte_ready,
  output logic        we,
  output logic [31:0] addr,
  output logic [31:0] datain,
  output logic        cpu_hold,
  output logic        done,
  output logic        error
);

`ifdef CARREGADOR_CHECKSUM_EN
  typedef enum logic [2:0] {S_IDLE, S_HDR, S_DATA, S_CSUM, S_DONE, S_ERR} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_HDR, S_DATA, S_DONE, S_ERR} state_t;
`endif

  state_t      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;       // byte position inside the current word
  logic [31:0] shift_q, shift_d;   // partially assembled word
  logic [31:0] nwords_q, nwords_d;
  logic [31:0] widx_q, widx_d;     // next word address; bounded by RAM_SIZE
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] datain_q, datain_d;
  logic        rdy_q, hold_q, done_q, err_q;
`ifdef CARREGADOR_CHECKSUM_EN
  logic [31:0] sum_q, sum_d;
`endif

  logic        acc, last;
  logic [31:0] word;

  assign acc  = byte_valid && rdy_q;
  assign last = (cnt_q == 2'd3);
  assign word = {shift_q[23:0], byte_in};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shift_d  = shift_q;
    nwords_d = nwords_q;
    widx_d   = widx_q;
    we_d     = 1'b0;
    addr_d   = addr_q;
    datain_d = datain_q;
`ifdef CARREGADOR_CHECKSUM_EN
    sum_d    = sum_q;
`endif
    unique case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d = S_HDR;
          cnt_d   = 2'd0;
          widx_d  = 32'd0;
`ifdef CARREGADOR_CHECKSUM_EN
          sum_d   = 32'd0;
`endif
        end
      end
      S_HDR: begin
        if (acc) begin
          shift_d = word;
          cnt_d   = cnt_q + 2'd1;
          if (last) begin
            nwords_d = word;
            if (word == 32'd0)
`ifdef CARREGADOR_CHECKSUM_EN
              state_d = S_CSUM;  // empty program still carries a checksum (of 0)
`else
              state_d = S_DONE;
`endif
            else if (word > 32'(RAM_SIZE))
              state_d = S_ERR;
            else
              state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (acc) begin
          shift_d = word;
          cnt_d   = cnt_q + 2'd1;
          if (last) begin
            // Write issues the cycle after the last byte; ready stays high so
            // the stream is never stalled by the write.
            we_d     = 1'b1;
            addr_d   = widx_q;
            datain_d = word;
            widx_d   = widx_q + 32'd1;
`ifdef CARREGADOR_CHECKSUM_EN
            sum_d    = sum_q + word;
            if (widx_q == nwords_q - 32'd1) state_d = S_CSUM;
`else
            if (widx_q == nwords_q - 32'd1) state_d = S_DONE;
`endif
          end
        end
      end
`ifdef CARREGADOR_CHECKSUM_EN
      S_CSUM: begin
        if (acc) begin
          shift_d = word;
          cnt_d   = cnt_q + 2'd1;
          if (last) state_d = (word == sum_q) ? S_DONE : S_ERR;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= 2'd0;
      shift_q  <= 32'd0;
      nwords_q <= 32'd0;
      widx_q   <= 32'd0;
      we_q     <= 1'b0;
      addr_q   <= 32'd0;
      datain_q <= 32'd0;
      rdy_q    <= 1'b0;
      hold_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
`ifdef CARREGADOR_CHECKSUM_EN
      sum_q    <= 32'd0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shift_q  <= shift_d;
      nwords_q <= nwords_d;
      widx_q   <= widx_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      datain_q <= datain_d;
      // Status outputs are registered decodes of the next state.
`ifdef CARREGADOR_CHECKSUM_EN
      sum_q    <= sum_d;
      rdy_q    <= (state_d == S_HDR) || (state_d == S_DATA) || (state_d == S_CSUM);
      hold_q   <= (state_d == S_HDR) || (state_d == S_DATA) || (state_d == S_CSUM) ||
                  (state_d == S_ERR);
`else
      rdy_q    <= (state_d == S_HDR) || (state_d == S_DATA);
      hold_q   <= (state_d == S_HDR) || (state_d == S_DATA) || (state_d == S_ERR);
`endif
      done_q   <= (state_d == S_DONE);
      err_q    <= (state_d == S_ERR);
    end
  end

  assign byte_ready = rdy_q;
  assign we         = we_q;
  assign addr       = addr_q;
  assign datain     = datain_q;
  assign cpu_hold   = hold_q;
  assign done       = done_q;
  assign error      = err_q;

endmodule

// File: tb/tb_carregador_de_programa.sv
// Self-checking bench for carregador_de_programa. The reference model works from
// the stream definition: header N, then N words, then an optional checksum.
// From that it predicts the list of memory writes and the final status.
module tb_carregador_de_programa;
  localparam int unsigned RAM = 1024;

  logic        clk = 1'b0, reset = 1'b0, start = 1'b0;
  logic [7:0]  byte_in = 8'h00;
  logic        byte_valid = 1'b0;
  logic        byte_ready, we, cpu_hold, done, error;
  logic [31:0] addr, datain;

  int n_tests = 0, n_fail = 0;

  logic [31:0] wq[$];               // data words of the current load
  logic [31:0] wr_addr[$], wr_data[$];

  carregador_de_programa #(.RAM_SIZE(RAM)) dut (
    .clk(clk), .reset(reset), .start(start), .byte_in(byte_in),
    .byte_valid(byte_valid), .byte_ready(byte_ready), .we(we), .addr(addr),
    .datain(datain), .cpu_hold(cpu_hold), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  // Capture every memory write.
  always @(negedge clk) if (we === 1'b1) begin
    wr_addr.push_back(addr);
    wr_data.push_back(datain);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  // Present one byte. Invalid gap cycles drive 0xFF, which must never be captured.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    repeat (gap) begin
      @(negedge clk);
      byte_valid = 1'b0;
      byte_in    = 8'hFF;
    end
    @(negedge clk);
    byte_valid = 1'b1;
    byte_in    = b;
    t = 0;
    while (!byte_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) chk("ready_timeout", 32'd0, 32'd1);
  endtask

  // Run one full load of N words, taken from wq. Then compare the captured writes
  // and the final status against the model.
  task automatic run_load(input logic [31:0] n, input int gapmax, input bit bad_csum);
    logic [7:0]  bq[$];
    logic [31:0] sum, cs;
    bit          exp_err;
    int          t, nexp;
    bq = {n[31:24], n[23:16], n[15:8], n[7:0]};
    exp_err = (n > RAM);
    nexp = 0;
    sum = 32'd0;
    if (!exp_err) begin
      nexp = int'(n);
      for (int k = 0; k < nexp; k++) begin
        bq.push_back(wq[k][31:24]); bq.push_back(wq[k][23:16]);
        bq.push_back(wq[k][15:8]);  bq.push_back(wq[k][7:0]);
        sum += wq[k];
      end
`ifdef CARREGADOR_CHECKSUM_EN
      cs = bad_csum ? sum + 32'd1 : sum;
      bq.push_back(cs[31:24]); bq.push_back(cs[23:16]);
      bq.push_back(cs[15:8]);  bq.push_back(cs[7:0]);
      exp_err = bad_csum;
`else
      cs = sum;
`endif
    end
    wr_addr.delete();
    wr_data.delete();
    pulse_start();
    chk("start_ready", {31'd0, byte_ready}, 32'd1);
    chk("start_clr", {30'd0, done, error}, 32'd0);
    foreach (bq[i]) begin
      send_byte(bq[i], gapmax == 0 ? 0 : $urandom_range(0, gapmax));
      if (i == 3 && n != 0 && n <= RAM) begin
        @(negedge clk) byte_valid = 1'b0;
        chk("hold_load", {31'd0, cpu_hold}, 32'd1);
      end
    end
    @(negedge clk) byte_valid = 1'b0;
    t = 0;
    while (!(done || error) && t < 20) begin
      @(negedge clk);
      t++;
    end
    repeat (2) @(negedge clk);
    chk("fin_done", {31'd0, done}, {31'd0, !exp_err});
    chk("fin_error", {31'd0, error}, {31'd0, exp_err});
    chk("fin_hold", {31'd0, cpu_hold}, {31'd0, exp_err});
    chk("fin_ready", {31'd0, byte_ready}, 32'd0);
    chk("fin_we", {31'd0, we}, 32'd0);
    chk("wr_count", wr_addr.size(), nexp);
    if (wr_addr.size() == nexp)
      for (int k = 0; k < nexp; k++) begin
        chk("wr_addr", wr_addr[k], k);
        chk("wr_data", wr_data[k], wq[k]);
      end
  endtask

  initial begin
    // Reset state
    reset = 1'b1;
    #1;
    chk("rst_we", {31'd0, we}, 32'd0);
    chk("rst_addr", addr, 32'd0);
    chk("rst_data", datain, 32'd0);
    chk("rst_flags", {28'd0, byte_ready, cpu_hold, done, error}, 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Two-word directed load, then again with gaps of 0xFF
    wq = {32'h11223344, 32'hAABBCCDD};
    run_load(32'd2, 0, 1'b0);
    run_load(32'd2, 1, 1'b0);
`ifdef CARREGADOR_CHECKSUM_EN
    run_load(32'd2, 0, 1'b1);     // trailing BB DE 00 22 -> error, words still written
`endif

    // Empty program
    wr_addr.delete();
    pulse_start();
    for (int i = 0; i < 4; i++) send_byte(8'h00, 0);
    @(negedge clk) byte_valid = 1'b0;
`ifdef CARREGADOR_CHECKSUM_EN
    chk("n0_csum_wait", {30'd0, done, byte_ready}, 32'd1);
    for (int i = 0; i < 4; i++) send_byte(8'h00, 0);
    @(negedge clk) byte_valid = 1'b0;
`endif
    chk("n0_done", {31'd0, done}, 32'd1);
    chk("n0_hold", {31'd0, cpu_hold}, 32'd0);
    chk("n0_nowr", wr_addr.size(), 32'd0);

    // Oversized header is rejected; start clears the error
    run_load(32'd1025, 0, 1'b0);
    pulse_start();
    chk("err_clr", {30'd0, error, byte_ready}, 32'd1);

    // Reset in the middle of a load
    for (int i = 0; i < 4; i++) send_byte(i == 3 ? 8'h02 : 8'h00, 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    @(negedge clk) byte_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("mid_rst", {27'd0, we, byte_ready, cpu_hold, done, error}, 32'd0);
    chk("mid_rst_ad", addr | datain, 32'd0);
    @(negedge clk) reset = 1'b0;
    run_load(32'd2, 0, 1'b0);

    // Largest accepted program
    wq.delete();
    for (int k = 0; k < RAM; k++) wq.push_back($urandom);
    run_load(RAM, 0, 1'b0);

    // Random loads
    for (int r = 0; r < 12; r++) begin
      logic [31:0] n;
      n = $urandom_range(0, 6);
      wq.delete();
      for (int k = 0; k < 6; k++) wq.push_back($urandom);
      run_load(n, $urandom_range(0, 3), $urandom_range(0, 3) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
